// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception sequencer (exc_ctrl, exc_prio_enc).
// Contents: CP0 cause codes, sequencer state encoding, CP0 status bit positions.
// No ports. Interrupt support in the users is selected by the EXC_IRQ_EN macro.
package exc_pkg;

  // Cause codes handed to CP0
  localparam logic [3:0] CAUSE_SYS = 4'b1000;
  localparam logic [3:0] CAUSE_BRK = 4'b1001;
  localparam logic [3:0] CAUSE_TEQ = 4'b1101;
  localparam logic [3:0] CAUSE_INT = 4'b0000;

  // CP0 status (reg 12) bit positions
  localparam int ST_IE       = 0;  // global interrupt/exception enable
  localparam int ST_SYS      = 1;
  localparam int ST_BRK      = 2;
  localparam int ST_TEQ      = 3;
  localparam int ST_IRQ_BASE = 8;  // irq[k] mask lives at status[ST_IRQ_BASE+k]

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_FLUSH,
    S_RETURN
  } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: masked priority encoder, TEQ > BREAK > SYSCALL > irq[0] > ... > irq[IRQ_W-1].
// Latency: purely combinational. Backpressure: none; the caller decides whether a hit is taken.
// Ports: syscall/brk/teq/teq_eq requests, status word in; vld, cause (and irq_hot one-hot with
// EXC_IRQ_EN defined, which also adds the irq_req input) out.
module exc_prio_enc
  import exc_pkg::*;
`ifdef EXC_IRQ_EN
#(
  parameter int IRQ_W = 4
)
`endif
(
  input  logic             syscall,
  input  logic             brk,
  input  logic             teq,
  input  logic             teq_eq,
`ifdef EXC_IRQ_EN
  input  logic [IRQ_W-1:0] irq_req,
  output logic [IRQ_W-1:0] irq_hot,
`endif
  input  logic [31:0]      status,
  output logic             vld,
  output logic [3:0]       cause
);

  logic ie;
  logic sync_vld;

  assign ie = status[ST_IE];

  // Lowest priority assigned first so later ifs override
  always_comb begin
    sync_vld = 1'b0;
    cause    = CAUSE_INT;
    if (syscall && status[ST_SYS]) begin
      sync_vld = 1'b1;
      cause    = CAUSE_SYS;
    end
    if (brk && status[ST_BRK]) begin
      sync_vld = 1'b1;
      cause    = CAUSE_BRK;
    end
    if (teq && teq_eq && status[ST_TEQ]) begin
      sync_vld = 1'b1;
      cause    = CAUSE_TEQ;
    end
  end

`ifdef EXC_IRQ_EN
  logic [IRQ_W-1:0] hot_raw;
  logic             irq_any;
  logic             unused_status;

  always_comb begin
    hot_raw = '0;
    irq_any = 1'b0;
    for (int k = IRQ_W - 1; k >= 0; k--) begin
      if (irq_req[k] && status[ST_IRQ_BASE + k]) begin
        hot_raw    = '0;
        hot_raw[k] = 1'b1;
        irq_any    = 1'b1;
      end
    end
  end

  // An interrupt only wins when no synchronous exception is present
  assign irq_hot = (ie && !sync_vld) ? hot_raw : '0;
  assign vld     = ie && (sync_vld || irq_any);
  assign unused_status = ^{status[31:ST_IRQ_BASE+IRQ_W], status[7:4]};
`else
  logic unused_status;
  assign vld           = ie && sync_vld;
  assign unused_status = ^status[31:4];
`endif

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/ERET sequencer in front of CP0; IDLE -> ENTRY|RETURN -> FLUSH -> IDLE.
// Latency: request in cycle N gives a registered cp0_exc/cp0_eret pulse in N+1, idle again at N+2+FLUSH_CYCLES.
// Backpressure: stall is held from the accept cycle until IDLE; requests arriving while busy are squashed.
// Ports: clk, rst (sync, active high), syscall/break/teq/teq_eq/eret requests, pc_in, status_in,
// irq (only with EXC_IRQ_EN defined) in; cp0_* commands, stall, flush, pc_sel, nest_depth, nest_ovf out.
module exc_ctrl
  import exc_pkg::*;
#(
`ifdef EXC_IRQ_EN
  parameter int IRQ_W        = 4,
`endif
  parameter int MAX_NEST     = 6,
  parameter int FLUSH_CYCLES = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall_req,
  input  logic             break_req,
  input  logic             teq_req,
  input  logic             teq_eq,
  input  logic             eret_req,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      status_in,
`ifdef EXC_IRQ_EN
  input  logic [IRQ_W-1:0] irq,
`endif
  output logic             cp0_exc,
  output logic [3:0]       cp0_cause,
  output logic             cp0_teq_exc,
  output logic             cp0_eret,
  output logic [31:0]      cp0_pc,
  output logic             stall,
  output logic             flush,
  output logic             pc_sel,
  output logic [2:0]       nest_depth,
  output logic             nest_ovf
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] flush_cnt;
  logic          idle;
  logic          req_vld;
  logic [3:0]    req_cause;

  assign idle = (state == S_IDLE);

`ifdef EXC_IRQ_EN
  logic [IRQ_W-1:0] pending;
  logic [IRQ_W-1:0] irq_req;
  logic [IRQ_W-1:0] irq_hot;
  logic             take;

  // Live lines are visible the cycle they rise; pending only remembers them
  assign irq_req = pending | irq;
  // A line counts as accepted when it wins in IDLE, even if refused for nesting,
  // so a refused interrupt cannot lock out ERET forever
  assign take    = idle && req_vld;

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= irq_req & ~({IRQ_W{take}} & irq_hot);
  end
`endif

  exc_prio_enc
`ifdef EXC_IRQ_EN
    #(.IRQ_W(IRQ_W))
`endif
    u_prio (
      .syscall (syscall_req),
      .brk     (break_req),
      .teq     (teq_req),
      .teq_eq  (teq_eq),
`ifdef EXC_IRQ_EN
      .irq_req (irq_req),
      .irq_hot (irq_hot),
`endif
      .status  (status_in),
      .vld     (req_vld),
      .cause   (req_cause)
    );

  // Combinational part covers the accept/eret cycle before the FSM leaves IDLE
  assign stall = !idle || req_vld || eret_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      flush_cnt   <= '0;
      cp0_exc     <= 1'b0;
      cp0_cause   <= CAUSE_INT;
      cp0_teq_exc <= 1'b0;
      cp0_eret    <= 1'b0;
      cp0_pc      <= '0;
      flush       <= 1'b0;
      pc_sel      <= 1'b0;
      nest_depth  <= '0;
      nest_ovf    <= 1'b0;
    end else begin
      cp0_exc     <= 1'b0;
      cp0_eret    <= 1'b0;
      cp0_teq_exc <= 1'b0;
      pc_sel      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_vld) begin
            if (nest_depth < 3'(MAX_NEST)) begin
              state       <= S_ENTRY;
              cp0_exc     <= 1'b1;
              cp0_cause   <= req_cause;
              cp0_teq_exc <= (req_cause == CAUSE_TEQ);
              cp0_pc      <= pc_in;
              pc_sel      <= 1'b1;
              flush       <= 1'b1;
              nest_depth  <= nest_depth + 3'd1;
            end else begin
              nest_ovf <= 1'b1;
            end
          end else if (eret_req) begin
            state    <= S_RETURN;
            cp0_eret <= 1'b1;
            pc_sel   <= 1'b1;
            flush    <= 1'b1;
            if (nest_depth != 3'd0) nest_depth <= nest_depth - 3'd1;
          end
        end
        S_ENTRY, S_RETURN: begin
          state     <= S_FLUSH;
          flush_cnt <= CW'(FLUSH_CYCLES - 1);
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= S_IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
